// File: rtl/conv_window_gen.sv
// Sliding KxK window generator: raster pixel stream in, valid-region windows out on valid/ready.
// Optional macro CONV_WINDOW_LAST_EN adds out_last, flagging the final window of each frame.
module conv_window_gen #(
   parameter int KERNEL_SIZE    = 3,
   parameter int PX_SIZE        = 8,
   parameter int INPUT_CHANNELS = 1,
   parameter int IMG_WIDTH      = 32,
   parameter int IMG_HEIGHT     = 32
) (
   input  logic                                                               clk,
   input  logic                                                               rst_n,
   input  logic [INPUT_CHANNELS-1:0][PX_SIZE-1:0]                             px_in,
   input  logic                                                               in_valid,
   output logic                                                               in_ready,
   output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] win_out,
   output logic                                                               out_valid,
   input  logic                                                               out_ready,
   output logic [$clog2(IMG_HEIGHT)-1:0]                                      out_row,
   output logic [$clog2(IMG_WIDTH)-1:0]                                       out_col
`ifdef CONV_WINDOW_LAST_EN
   ,
   output logic                                                               out_last
`endif
);

   localparam int ROW_W = $clog2(IMG_HEIGHT);
   localparam int COL_W = $clog2(IMG_WIDTH);

   typedef logic [INPUT_CHANNELS-1:0][PX_SIZE-1:0] pixel_t;

   pixel_t                                    line_buf_r [KERNEL_SIZE-1][IMG_WIDTH];
   pixel_t [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0] win_r;
   pixel_t [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0] win_nxt_s;
   pixel_t [KERNEL_SIZE-1:0]                  col_s;
   pixel_t [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0] win_out_r;

   logic [ROW_W-1:0] row_r;
   logic [COL_W-1:0] col_r;
   logic [ROW_W-1:0] out_row_r;
   logic [COL_W-1:0] out_col_r;
   logic             out_valid_r;
   logic             in_ready_s;
   logic             accept_s;
   logic             emit_s;
   logic             col_last_s;
   logic             row_last_s;

   assign in_ready_s = !out_valid_r || out_ready;
   assign accept_s   = in_valid && in_ready_s;
   assign col_last_s = (col_r == COL_W'(IMG_WIDTH - 1));
   assign row_last_s = (row_r == ROW_W'(IMG_HEIGHT - 1));
   // Warm-up pixels (top K-1 rows, left K-1 columns) never complete a window.
   assign emit_s     = accept_s && (row_r >= ROW_W'(KERNEL_SIZE - 1))
                                && (col_r >= COL_W'(KERNEL_SIZE - 1));

   // New rightmost column (oldest buffer on top, live pixel at the bottom) and shifted window.
   always_comb begin
      col_s     = '0;
      win_nxt_s = '0;
      for (int i = 0; i < KERNEL_SIZE - 1; i++) begin
         col_s[i] = line_buf_r[KERNEL_SIZE - 2 - i][col_r];
      end
      col_s[KERNEL_SIZE-1] = px_in;
      for (int i = 0; i < KERNEL_SIZE; i++) begin
         for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
            win_nxt_s[i][j] = win_r[i][j+1];
         end
         win_nxt_s[i][KERNEL_SIZE-1] = col_s[i];
      end
   end

   // Line buffers rotate at the current column; contents need no reset.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         line_buf_r[0][col_r] <= px_in;
         for (int n = 1; n < KERNEL_SIZE - 1; n++) begin
            line_buf_r[n][col_r] <= line_buf_r[n-1][col_r];
         end
      end
   end

   // Internal shift window and raster position counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_r <= '0;
         row_r <= '0;
         col_r <= '0;
      end else if (accept_s) begin
         win_r <= win_nxt_s;
         if (col_last_s) begin
            col_r <= '0;
            row_r <= row_last_s ? '0 : row_r + ROW_W'(1);
         end else begin
            col_r <= col_r + COL_W'(1);
         end
      end
   end

   // Output slot: load on emit, clear on consume, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         win_out_r   <= '0;
         out_row_r   <= '0;
         out_col_r   <= '0;
      end else if (emit_s) begin
         out_valid_r <= 1'b1;
         win_out_r   <= win_nxt_s;
         out_row_r   <= row_r;
         out_col_r   <= col_r;
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

`ifdef CONV_WINDOW_LAST_EN
   logic out_last_r;

   // Last-window flag travels with the window it describes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_last_r <= 1'b0;
      end else if (emit_s) begin
         out_last_r <= row_last_s && col_last_s;
      end
   end

   assign out_last = out_last_r;
`endif

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign win_out   = win_out_r;
   assign out_row   = out_row_r;
   assign out_col   = out_col_r;

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Producer side of the convolution processing element's window interface.
- Accepts a raster-order pixel stream, one multi-channel pixel per handshake.
- Keeps K-1 line buffers plus a KxK shift window.
- Presents each complete KxK neighbourhood (valid region, no padding) on a registered valid/ready output that drives the PE's image window input directly.

Parameters:
- KERNEL_SIZE, 3, window width/height (square), >=2
- PX_SIZE, 8, bits per pixel per channel
- INPUT_CHANNELS, 1, channels per pixel
- IMG_WIDTH, 32, pixels per row, >= KERNEL_SIZE
- IMG_HEIGHT, 32, rows per frame, >= KERNEL_SIZE

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- px_in  in  [INPUT_CHANNELS-1:0][PX_SIZE-1:0]  input pixel, raster order
- in_valid  in  1  px_in valid
- in_ready  out  1  block can accept px_in this cycle
- win_out  out  [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0]  window, [i][j]: i = row offset (0 = top/oldest), j = column offset (0 = leftmost/oldest)
- out_valid  out  1  win_out holds an unconsumed window
- out_ready  in  1  consumer accepts win_out
- out_row  out  $clog2(IMG_HEIGHT)  image row of window's bottom-right pixel
- out_col  out  $clog2(IMG_WIDTH)  image column of window's bottom-right pixel

Behaviour:
- Reset (async assert, sync-safe deassert on clk):
  - out_valid=0; win_out, out_row, out_col, internal window, and row/col counters = 0.
  - Line-buffer contents are don't-care.
- Accept: a pixel is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready, combinational. It is 1 immediately after reset.
- On each accept at position (row r, col c):
  - Every window column shifts left by one (column j <= j+1).
  - The new rightmost column [i][K-1] is {line_buf[K-2..0] at address c, px_in}: top rows come from the oldest buffer, [K-1][K-1] = px_in.
  - Line buffers rotate at address c: buf0 <= px_in, buf_n <= buf_{n-1}.
  - c increments; at IMG_WIDTH-1 it wraps to 0 and r increments.
  - r wraps at IMG_HEIGHT-1 to 0, which starts a new frame with no idle cycle required.
- Emit: if the accepted pixel has r >= K-1 and c >= K-1, then on the next edge:
  - win_out is loaded with the updated window;
  - out_row=r, out_col=c;
  - out_valid=1.
- Latency: one cycle from the accept edge to out_valid.
- Output hold: out_valid stays high and win_out, out_row, out_col stay stable until out_valid && out_ready.
- Consume without a new window: out_valid clears on the consume edge.
- Simultaneous consume and window-producing accept: out_valid stays 1 and the new window loads. Full throughput is one window per cycle.
- Backpressure: out_valid && !out_ready forces in_ready=0. No pixel is lost or duplicated.
- Warm-up positions (r<K-1 or c<K-1):
  - The pixel updates internal state only.
  - No window is emitted. Stale columns from the previous row are never emitted.
- Windows per frame: exactly (IMG_HEIGHT-K+1)*(IMG_WIDTH-K+1).
- Line-buffer state: the first K-1 rows of each frame overwrite it, so no clearing is needed between frames.
- Reset mid-frame: counters return to (0,0), out_valid drops, and the pending window is discarded. The next pixel is treated as frame pixel (0,0).
- in_valid low: no state change; the window and counters hold.
- Line buffers: depth IMG_WIDTH, width INPUT_CHANNELS*PX_SIZE, single read/write address per cycle (inferable as RAM or registers).

Optional Feature:
- Macro: CONV_WINDOW_LAST_EN.
- Defined: adds output port out_last (1 bit, reset 0).
  - It is loaded with the window and equals 1 exactly when out_row=IMG_HEIGHT-1 and out_col=IMG_WIDTH-1.
  - It is held under backpressure like win_out.
- Undefined: port absent and no logic generated. All other behaviour is identical.

Test Plan:
- K=3, 4x4, C=1, px value = 4r+c, out_ready=1, in_valid=1 continuous:
  - first out_valid occurs one cycle after pixel 10;
  - win_out rows {0,1,2},{4,5,6},{8,9,10};
  - exactly 4 windows, at (2,2),(2,3),(3,2),(3,3);
  - last window {5,6,7},{9,10,11},{13,14,15}.
- Same stream, out_ready=0 for 5 cycles after the first window:
  - in_ready=0 throughout;
  - win_out held at {0,1,2},{4,5,6},{8,9,10};
  - after release the remaining 3 windows arrive with correct contents and no loss or duplication.
- Random in_valid gaps (50%) and random out_ready:
  - window sequence and contents match the continuous case;
  - out_valid never drops without a consume.
- Two back-to-back frames, second frame px = 100+4r+c: the second frame's first window is {100,101,102},{104,105,106},{108,109,110}, with no window built from stale first-frame data.
- Assert rst_n low asynchronously mid-frame (after pixel 9):
  - out_valid=0 immediately;
  - a fresh frame then yields first window {0,1,2},{4,5,6},{8,9,10}.
- With CONV_WINDOW_LAST_EN: out_last=1 only on window (3,3) of each frame and held under backpressure. Without the macro, the bench compiles with no out_last port.
